// File: rtl/cfu_bus_pkg.sv
// Shared types and sizing for the CFU bus initiator.
// Holds the transaction state encoding and the default timeout.
package cfu_bus_pkg;

  localparam int FUNC_ID_W          = 3;
  localparam int DATA_W             = 32;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RSP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Timer needs to hold 0..TIMEOUT_CYCLES-1; never narrower than one bit.
  function automatic int timer_width(input int unsigned cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/cfu_initiator.sv
// CPU-side request/result port bridged onto a CFU cmd/rsp bus, one transaction in flight.
// Zero-wait responder: result two cycles after request acceptance; timeout aborts a silent responder.
module cfu_initiator
  import cfu_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [FUNC_ID_W-1:0] req_function_id,
  input  logic [DATA_W-1:0]    req_in0,
  input  logic [DATA_W-1:0]    req_in1,

  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [DATA_W-1:0]    res_data,
  output logic                 res_err,
  output logic                 res_timeout,

  output logic                 proto_err,

  output logic                 io_bus_cmd_valid,
  input  logic                 io_bus_cmd_ready,
  output logic [FUNC_ID_W-1:0] io_bus_cmd_payload_function_id,
  output logic [DATA_W-1:0]    io_bus_cmd_payload_inputs_0,
  output logic [DATA_W-1:0]    io_bus_cmd_payload_inputs_1,

  input  logic                 io_bus_rsp_valid,
  output logic                 io_bus_rsp_ready,
  input  logic                 io_bus_rsp_payload_response_ok,
  input  logic [DATA_W-1:0]    io_bus_rsp_payload_outputs_0
);

  localparam int TW = timer_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST =
    TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  state_e state, state_nxt;

  logic [FUNC_ID_W-1:0] fid_q;
  logic [DATA_W-1:0]    in0_q;
  logic [DATA_W-1:0]    in1_q;
  logic [DATA_W-1:0]    res_data_q;
  logic                 res_err_q;
  logic                 res_timeout_q;
  logic                 proto_err_q;
  logic [TW-1:0]        timer_q;

  logic accept;
  logic capture;
  logic expire;
  logic stray_beat;
  logic timer_hit;

  assign timer_hit = TIMEOUT_EN && (timer_q == TIMER_LAST);

  always_comb begin
    state_nxt        = state;
    req_ready        = 1'b0;
    res_valid        = 1'b0;
    io_bus_cmd_valid = 1'b0;
    io_bus_rsp_ready = 1'b0;
    accept           = 1'b0;
    capture          = 1'b0;
    expire           = 1'b0;
    stray_beat       = 1'b0;

    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = ST_CMD;
        end
      end

      ST_CMD: begin
        // rsp_ready is high here too so a responder that ties cmd_ready to
        // rsp_ready still sees the command accepted.
        io_bus_cmd_valid = 1'b1;
        io_bus_rsp_ready = 1'b1;
        stray_beat       = io_bus_rsp_valid && !io_bus_cmd_ready;
        if (io_bus_cmd_ready && io_bus_rsp_valid) begin
          capture   = 1'b1;
          state_nxt = ST_DONE;
        end else if (timer_hit) begin
          expire    = 1'b1;
          state_nxt = ST_DONE;
        end else if (io_bus_cmd_ready) begin
          state_nxt = ST_RSP;
        end
      end

      ST_RSP: begin
        io_bus_rsp_ready = 1'b1;
        if (io_bus_rsp_valid) begin
          capture   = 1'b1;
          state_nxt = ST_DONE;
        end else if (timer_hit) begin
          expire    = 1'b1;
          state_nxt = ST_DONE;
        end
      end

      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = ST_IDLE;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= ST_IDLE;
      fid_q         <= '0;
      in0_q         <= '0;
      in1_q         <= '0;
      res_data_q    <= '0;
      res_err_q     <= 1'b0;
      res_timeout_q <= 1'b0;
      proto_err_q   <= 1'b0;
      timer_q       <= '0;
    end else begin
      state <= state_nxt;

      if (accept) begin
        fid_q   <= req_function_id;
        in0_q   <= req_in0;
        in1_q   <= req_in1;
        timer_q <= '0;
      end else if (state == ST_CMD || state == ST_RSP) begin
        timer_q <= timer_q + 1'b1;
      end

      if (capture) begin
        res_data_q    <= io_bus_rsp_payload_outputs_0;
        res_err_q     <= !io_bus_rsp_payload_response_ok;
        res_timeout_q <= 1'b0;
      end else if (expire) begin
        res_data_q    <= '0;
        res_err_q     <= 1'b1;
        res_timeout_q <= 1'b1;
      end

      if (stray_beat) proto_err_q <= 1'b1;
    end
  end

  assign io_bus_cmd_payload_function_id = fid_q;
  assign io_bus_cmd_payload_inputs_0    = in0_q;
  assign io_bus_cmd_payload_inputs_1    = in1_q;

  assign res_data    = res_data_q;
  assign res_err     = res_err_q;
  assign res_timeout = res_timeout_q;
  assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_cfu_initiator.sv
// Self-checking bench for cfu_initiator: a behavioural CFU responder (auto or scripted)
// and per-scenario tasks comparing against a function-level reference model.
module tb_cfu_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_function_id = '0;
  logic [31:0] req_in0 = '0;
  logic [31:0] req_in1 = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        res_err;
  logic        res_timeout;
  logic        proto_err;
  logic        io_bus_cmd_valid;
  logic        io_bus_cmd_ready;
  logic [2:0]  io_bus_cmd_payload_function_id;
  logic [31:0] io_bus_cmd_payload_inputs_0;
  logic [31:0] io_bus_cmd_payload_inputs_1;
  logic        io_bus_rsp_valid;
  logic        io_bus_rsp_ready;
  logic        io_bus_rsp_payload_response_ok;
  logic [31:0] io_bus_rsp_payload_outputs_0;

  // Responder controls: auto = combinational zero-wait responder, else scripted.
  logic        auto_mode = 1'b1;
  logic        m_cmd_ready = 1'b0;
  logic        m_rsp_valid = 1'b0;
  logic        m_ok = 1'b1;
  logic [31:0] m_out = '0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cfu_initiator #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_function_id(req_function_id), .req_in0(req_in0), .req_in1(req_in1),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_err(res_err), .res_timeout(res_timeout), .proto_err(proto_err),
    .io_bus_cmd_valid(io_bus_cmd_valid), .io_bus_cmd_ready(io_bus_cmd_ready),
    .io_bus_cmd_payload_function_id(io_bus_cmd_payload_function_id),
    .io_bus_cmd_payload_inputs_0(io_bus_cmd_payload_inputs_0),
    .io_bus_cmd_payload_inputs_1(io_bus_cmd_payload_inputs_1),
    .io_bus_rsp_valid(io_bus_rsp_valid), .io_bus_rsp_ready(io_bus_rsp_ready),
    .io_bus_rsp_payload_response_ok(io_bus_rsp_payload_response_ok),
    .io_bus_rsp_payload_outputs_0(io_bus_rsp_payload_outputs_0)
  );

  // Reference CFU functions: 0 byte sum, 1 byte swap, 2 bit reverse, others xor.
  function automatic logic [31:0] cfu_model(input logic [2:0] id, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    case (id)
      3'd0: for (int i = 0; i < 4; i++) r = r + 32'(a[8*i +: 8]) + 32'(b[8*i +: 8]);
      3'd1: r = {a[7:0], a[15:8], a[23:16], a[31:24]};
      3'd2: for (int i = 0; i < 32; i++) r[i] = a[31-i];
      default: r = a ^ b;
    endcase
    return r;
  endfunction

  always_comb begin
    if (auto_mode) begin
      io_bus_rsp_valid               = io_bus_cmd_valid;
      io_bus_cmd_ready               = io_bus_rsp_ready;
      io_bus_rsp_payload_response_ok = 1'b1;
      io_bus_rsp_payload_outputs_0   = cfu_model(io_bus_cmd_payload_function_id,
                                                 io_bus_cmd_payload_inputs_0,
                                                 io_bus_cmd_payload_inputs_1);
    end else begin
      io_bus_rsp_valid               = m_rsp_valid;
      io_bus_cmd_ready               = m_cmd_ready;
      io_bus_rsp_payload_response_ok = m_ok;
      io_bus_rsp_payload_outputs_0   = m_out;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Drives one request and waits for its result; lat = cycles from acceptance (-1 if none).
  task automatic do_txn(input logic [2:0] id, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] d, output logic e, output logic t);
    int n;
    req_function_id = id; req_in0 = a; req_in1 = b; req_valid = 1'b1; n = 0;
    while (!req_ready && n < 50) begin step(); n++; end
    step();
    req_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 64) begin step(); lat++; end
    if (!res_valid) lat = -1;
    d = res_data; e = res_err; t = res_timeout;
    res_ready = 1'b1; step(); res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(2);
    n_checks++;
    if ({req_ready, res_valid, io_bus_cmd_valid, io_bus_rsp_ready} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_handshake got=%b want=1000", {req_ready, res_valid, io_bus_cmd_valid, io_bus_rsp_ready});
    end
    n_checks++;
    if ({res_data, res_err, res_timeout, proto_err} !== 35'd0) begin
      n_fail++; $display("FAIL reset_result data=%h err=%b to=%b perr=%b want all 0", res_data, res_err, res_timeout, proto_err);
    end
    n_checks++;
    if ({io_bus_cmd_payload_function_id, io_bus_cmd_payload_inputs_0, io_bus_cmd_payload_inputs_1} !== 67'd0) begin
      n_fail++; $display("FAIL reset_payload got=%h want=0", {io_bus_cmd_payload_function_id, io_bus_cmd_payload_inputs_0, io_bus_cmd_payload_inputs_1});
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_known_vectors();
    logic [2:0]  ids [3] = '{3'd0, 3'd1, 3'd2};
    logic [31:0] a0  [3] = '{32'h01020304, 32'h12345678, 32'h00000001};
    logic [31:0] b0  [3] = '{32'h10203040, 32'h0, 32'h0};
    logic [31:0] exp [3] = '{32'h000000AA, 32'h78563412, 32'h80000000};
    int lat; logic [31:0] d; logic e, t;
    auto_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_txn(ids[i], a0[i], b0[i], lat, d, e, t);
      n_checks++;
      if (d !== exp[i] || e !== 1'b0 || t !== 1'b0) begin
        n_fail++; $display("FAIL vector%0d data=%h err=%b to=%b want data=%h err=0 to=0", i, d, e, t, exp[i]);
      end
      n_checks++;
      if (lat !== 2) begin n_fail++; $display("FAIL vector%0d_latency got=%0d want=2", i, lat); end
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] d, a, b; logic e, t; logic [2:0] id;
    auto_mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      id = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
      do_txn(id, a, b, lat, d, e, t);
      n_checks++;
      if (d !== cfu_model(id, a, b) || e !== 1'b0 || lat !== 2) begin
        n_fail++; $display("FAIL random%0d id=%0d data=%h lat=%0d err=%b want data=%h lat=2 err=0", i, id, d, lat, e, cfu_model(id, a, b));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    int cyc, last, accepted, results;
    logic took;
    auto_mode = 1'b1; res_ready = 1'b1; req_valid = 1'b1;
    req_function_id = 3'($urandom_range(0, 7)); req_in0 = $urandom; req_in1 = $urandom;
    cyc = 0; last = -1; accepted = 0; results = 0;
    while ((accepted < 6 || exp_q.size() != 0) && cyc < 200) begin
      if (res_valid) begin
        n_checks++;
        if (exp_q.size() == 0 || res_data !== exp_q[0]) begin
          n_fail++; $display("FAIL b2b_data cycle=%0d got=%h want=%h", cyc, res_data, (exp_q.size() != 0) ? exp_q[0] : 32'hx);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        if (last >= 0) begin
          n_checks++;
          if (cyc - last !== 3) begin n_fail++; $display("FAIL b2b_spacing got=%0d want=3", cyc - last); end
        end
        last = cyc; results++;
      end
      took = req_valid && req_ready;
      if (took) begin exp_q.push_back(cfu_model(req_function_id, req_in0, req_in1)); accepted++; end
      step(); cyc++;
      if (took) begin
        req_function_id = 3'($urandom_range(0, 7)); req_in0 = $urandom; req_in1 = $urandom;
        if (accepted >= 6) req_valid = 1'b0;
      end
    end
    n_checks++;
    if (results !== 6) begin n_fail++; $display("FAIL b2b_count got=%0d want=6", results); end
    res_ready = 1'b0; req_valid = 1'b0;
  endtask

  task automatic test_stall();
    logic [2:0] id; logic [31:0] a, b, r;
    int bad;
    auto_mode = 1'b0; m_cmd_ready = 1'b0; m_rsp_valid = 1'b0; m_ok = 1'b1;
    id = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom; r = $urandom;
    req_function_id = id; req_in0 = a; req_in1 = b; req_valid = 1'b1;
    step();
    req_valid = 1'b0; req_in0 = ~a; req_in1 = ~b; req_function_id = ~id;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (io_bus_cmd_valid !== 1'b1 || io_bus_cmd_payload_function_id !== id ||
          io_bus_cmd_payload_inputs_0 !== a || io_bus_cmd_payload_inputs_1 !== b) bad++;
      step();
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL stall_payload unstable_cycles=%0d want=0", bad); end
    m_cmd_ready = 1'b1; step(); m_cmd_ready = 1'b0;
    n_checks++;
    if ({io_bus_cmd_valid, io_bus_rsp_ready} !== 2'b01) begin
      n_fail++; $display("FAIL stall_rsp_phase cmd_valid,rsp_ready=%b want=01", {io_bus_cmd_valid, io_bus_rsp_ready});
    end
    step(2);
    m_rsp_valid = 1'b1; m_out = r; step(); m_rsp_valid = 1'b0;
    n_checks++;
    if (res_valid !== 1'b1 || res_data !== r || res_err !== 1'b0 || res_timeout !== 1'b0) begin
      n_fail++; $display("FAIL stall_result valid=%b data=%h err=%b to=%b want 1/%h/0/0", res_valid, res_data, res_err, res_timeout, r);
    end
    res_ready = 1'b1; step(); res_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int cnt;
    auto_mode = 1'b0; m_cmd_ready = 1'b0; m_rsp_valid = 1'b0;
    req_function_id = 3'd5; req_in0 = $urandom; req_in1 = $urandom; req_valid = 1'b1;
    step();
    req_valid = 1'b0; cnt = 0;
    while (io_bus_cmd_valid && cnt < 100) begin cnt++; step(); end
    n_checks++;
    if (cnt !== 16) begin n_fail++; $display("FAIL timeout_cmd_cycles got=%0d want=16", cnt); end
    n_checks++;
    if (res_valid !== 1'b1 || res_data !== 32'd0 || res_err !== 1'b1 || res_timeout !== 1'b1) begin
      n_fail++; $display("FAIL timeout_result valid=%b data=%h err=%b to=%b want 1/0/1/1", res_valid, res_data, res_err, res_timeout);
    end
    res_ready = 1'b1; step(); res_ready = 1'b0;
  endtask

  task automatic test_error_rsp();
    auto_mode = 1'b0; m_cmd_ready = 1'b1; m_rsp_valid = 1'b1; m_ok = 1'b0; m_out = 32'hDEADBEEF;
    req_function_id = 3'd3; req_in0 = $urandom; req_in1 = $urandom; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    m_rsp_valid = 1'b0; m_ok = 1'b1;
    n_checks++;
    if (res_valid !== 1'b1 || res_data !== 32'hDEADBEEF || res_err !== 1'b1 || res_timeout !== 1'b0) begin
      n_fail++; $display("FAIL err_result valid=%b data=%h err=%b to=%b want 1/deadbeef/1/0", res_valid, res_data, res_err, res_timeout);
    end
    n_checks++;
    if (proto_err !== 1'b0) begin n_fail++; $display("FAIL err_no_proto got=%b want=0", proto_err); end
    res_ready = 1'b1; step(); res_ready = 1'b0;
  endtask

  task automatic test_proto_err();
    auto_mode = 1'b0; m_cmd_ready = 1'b0; m_rsp_valid = 1'b1; m_out = 32'h0BAD0BAD; m_ok = 1'b1;
    req_function_id = 3'd1; req_in0 = 32'h11223344; req_in1 = 32'h0; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    m_rsp_valid = 1'b0;
    n_checks++;
    if (proto_err !== 1'b1 || io_bus_cmd_valid !== 1'b1) begin
      n_fail++; $display("FAIL proto_set perr=%b cmd_valid=%b want 1/1", proto_err, io_bus_cmd_valid);
    end
    m_cmd_ready = 1'b1; step(); m_cmd_ready = 1'b0;
    m_rsp_valid = 1'b1; m_out = 32'h00001234; step(); m_rsp_valid = 1'b0;
    n_checks++;
    if (res_valid !== 1'b1 || res_data !== 32'h00001234 || res_err !== 1'b0) begin
      n_fail++; $display("FAIL proto_result valid=%b data=%h err=%b want 1/00001234/0", res_valid, res_data, res_err);
    end
    res_ready = 1'b1; step(); res_ready = 1'b0;
    n_checks++;
    if (proto_err !== 1'b1) begin n_fail++; $display("FAIL proto_sticky got=%b want=1", proto_err); end
  endtask

  task automatic test_reset_mid();
    int seen; int lat; logic [31:0] d; logic e, t;
    auto_mode = 1'b0; m_cmd_ready = 1'b1; m_rsp_valid = 1'b0;
    req_function_id = 3'd2; req_in0 = $urandom; req_in1 = $urandom; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    m_cmd_ready = 1'b0;
    n_checks++;
    if ({io_bus_cmd_valid, io_bus_rsp_ready} !== 2'b01) begin
      n_fail++; $display("FAIL rstmid_in_rsp cmd_valid,rsp_ready=%b want=01", {io_bus_cmd_valid, io_bus_rsp_ready});
    end
    rst = 1'b0; step(); rst = 1'b1;
    n_checks++;
    if ({io_bus_cmd_valid, io_bus_rsp_ready, res_valid, req_ready, proto_err} !== 5'b00010) begin
      n_fail++; $display("FAIL rstmid_after got=%b want=00010", {io_bus_cmd_valid, io_bus_rsp_ready, res_valid, req_ready, proto_err});
    end
    seen = 0;
    for (int i = 0; i < 4; i++) begin if (res_valid || io_bus_cmd_valid) seen++; step(); end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL rstmid_silent active_cycles=%0d want=0", seen); end
    auto_mode = 1'b1;
    do_txn(3'd1, 32'hA1B2C3D4, 32'h0, lat, d, e, t);
    n_checks++;
    if (d !== 32'hD4C3B2A1 || e !== 1'b0 || lat !== 2) begin
      n_fail++; $display("FAIL rstmid_recover data=%h err=%b lat=%0d want d4c3b2a1/0/2", d, e, lat);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_known_vectors();
    test_random();
    test_back_to_back();
    test_stall();
    test_timeout();
    test_error_rsp();
    test_proto_err();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
